// File: rtl/shiftreg_cmd_seq_if.sv
// Command handshake bundle for shiftreg_cmd_seq.
// The producer drives valid/data/op/cnt; the sequencer answers with ready.
interface shiftreg_cmd_seq_if #(
    parameter int DW = 4,
    parameter int OW = 2,
    parameter int CW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_data;
    logic [OW-1:0] cmd_op;
    logic [CW-1:0] cmd_cnt;

    modport master (
        output cmd_valid, cmd_data, cmd_op, cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_op, cmd_cnt,
        output cmd_ready
    );
endinterface

// File: rtl/shiftreg_cmd_seq.sv
// Command sequencer feeding the i/op inputs of a 4-bit shift register.
// Commands are buffered in a DEPTH-entry FIFO; each one holds its data/op
// pair on the outputs for cnt+1 consecutive clocks, back-to-back with no gap.
// Optional feature: define SHIFTREG_SEQ_FLUSH_EN to add a synchronous flush
// input that empties the FIFO and aborts the command being issued.
module shiftreg_cmd_seq #(
    parameter int            DW      = 4,
    parameter int            OW      = 2,
    parameter int            CW      = 3,
    parameter int            DEPTH   = 4,
    parameter logic [OW-1:0] IDLE_OP = {OW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SHIFTREG_SEQ_FLUSH_EN
    input  logic              flush,
`endif
    shiftreg_cmd_seq_if.slave cmd,
    output logic [DW-1:0]     i,
    output logic [OW-1:0]     op,
    output logic              busy,
    output logic              done
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [OW-1:0] op;
        logic [CW-1:0] cnt;
    } entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        wr_entry;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [AW:0]   occ_next;
    logic          push;
    logic          pop;
    logic          do_flush;
    state_t        state;
    logic [CW-1:0] cnt;

`ifdef SHIFTREG_SEQ_FLUSH_EN
    assign do_flush = flush;
`else
    assign do_flush = 1'b0;
`endif

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a slot early.
    assign cmd.cmd_ready = (occ != FULL);
    assign push          = cmd.cmd_valid && cmd.cmd_ready && !do_flush;
    assign wr_entry      = {cmd.cmd_data, cmd.cmd_op, cmd.cmd_cnt};
    assign head          = mem[rd_ptr];

    // Take the head when idle, or on the final cycle of the current command.
    assign pop = (occ != '0) && !do_flush && ((state == IDLE) || (cnt == '0));

    // Next occupancy; also feeds the registered busy flag.
    always_comb begin
        // NOTE: default assignment first so every path drives occ_next and no latch is inferred.
        occ_next = occ;
        if (do_flush) begin
            occ_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_next = occ + OCC_ONE;
                2'b01:   occ_next = occ - OCC_ONE;
                default: occ_next = occ;
            endcase
        end
    end

    // FIFO storage write.
    // NOTE: storage has no reset; emptiness is tracked by the pointers and occupancy alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy.
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (do_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            occ <= occ_next;
        end
    end

    // Issue FSM with registered i/op/busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            i     <= '0;
            op    <= IDLE_OP;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (do_flush) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= IDLE_OP;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (pop) begin
            state <= ISSUE;
            cnt   <= head.cnt;
            i     <= head.data;
            op    <= head.op;
            busy  <= 1'b1;
            done  <= (head.cnt == '0);
        end else if ((state == ISSUE) && (cnt != '0)) begin
            cnt   <= cnt - CNT_ONE;
            busy  <= 1'b1;
            done  <= (cnt == CNT_ONE);
        end else begin
            // Idle with nothing to pop, or last cycle with an empty FIFO.
            state <= IDLE;
            op    <= IDLE_OP;
            busy  <= (occ_next != '0);
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shiftreg_cmd_seq.sv
// Self-checking bench for shiftreg_cmd_seq: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_shiftreg_cmd_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [3:0] dut_i;
    logic [1:0] dut_op;
    logic       dut_busy;
    logic       dut_done;

    int total = 0;
    int bad   = 0;

    shiftreg_cmd_seq_if #(.DW(4), .OW(2), .CW(3)) cmd_if ();

    shiftreg_cmd_seq dut (
        .clk  (clk),
        .rst  (rst),
`ifdef SHIFTREG_SEQ_FLUSH_EN
        .flush(flush),
`endif
        .cmd  (cmd_if),
        .i    (dut_i),
        .op   (dut_op),
        .busy (dut_busy),
        .done (dut_done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending commands plus the one on the outputs.
    typedef struct {
        logic [3:0] data;
        logic [1:0] op;
        int         cnt;
    } cmd_t;

    cmd_t       q[$];
    bit         m_issuing = 0;
    int         m_left    = 0;
    logic [3:0] m_i       = '0;
    logic [1:0] m_op      = '0;
    int         acc_cnt   = 0;

    task automatic model_reset();
        q.delete();
        m_issuing = 0;
        m_left    = 0;
        m_i       = '0;
        m_op      = '0;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            cmd_t c;
            bit   accept;
            accept = cmd_if.cmd_valid && (q.size() < DEPTH) && !flush;
            if (flush) begin
                q.delete();
                m_issuing = 0;
            end else begin
                if (m_issuing && m_left > 0) begin
                    m_left--;
                end else if (q.size() > 0) begin
                    c         = q.pop_front();
                    m_issuing = 1;
                    m_left    = c.cnt;
                    m_i       = c.data;
                    m_op      = c.op;
                end else begin
                    m_issuing = 0;
                end
                if (accept) begin
                    c.data = cmd_if.cmd_data;
                    c.op   = cmd_if.cmd_op;
                    c.cnt  = int'(cmd_if.cmd_cnt);
                    q.push_back(c);
                    acc_cnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_i",     32'(dut_i),            32'(m_i));
        check("model_op",    32'(dut_op),           m_issuing ? 32'(m_op) : 32'd0);
        check("model_done",  32'(dut_done),         32'(m_issuing && m_left == 0));
        check("model_busy",  32'(dut_busy),         32'(m_issuing || q.size() != 0));
        check("model_ready", 32'(cmd_if.cmd_ready), 32'(q.size() < DEPTH));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input bit v, input logic [3:0] d, input logic [1:0] o, input logic [2:0] c);
        cmd_if.cmd_valid = v;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_op    = o;
        cmd_if.cmd_cnt   = c;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (dut_busy && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    initial begin
        logic [1:0] exp_ops  [6] = '{2'b11, 2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
        logic       exp_done [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] ops  [6];
        logic       dns  [6];

        set_cmd(0, '0, '0, '0);
        model_reset();
        #12;
        rst = 1'b0;
        tick();
        check("reset_op",   32'(dut_op),   32'd0);
        check("reset_busy", 32'(dut_busy), 32'd0);
        tick();

        // Single-cycle command: valid one edge after the push.
        set_cmd(1, 4'b1011, 2'b01, 3'd0);
        tick();
        set_cmd(0, '0, '0, '0);
        tick();
        check("t1_i",    32'(dut_i),    32'hB);
        check("t1_op",   32'(dut_op),   32'h1);
        check("t1_done", 32'(dut_done), 32'd1);
        tick();
        check("t1_op_idle", 32'(dut_op),   32'd0);
        check("t1_done_lo", 32'(dut_done), 32'd0);
        check("t1_busy_lo", 32'(dut_busy), 32'd0);

        // cnt=3: four issue cycles, done on the last.
        set_cmd(1, 4'b0111, 2'b10, 3'd3);
        tick();
        set_cmd(0, '0, '0, '0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_op",   32'(dut_op),   (k < 4) ? 32'h2 : 32'h0);
            check("t2_done", 32'(dut_done), 32'(k == 3));
            check("t2_i",    32'(dut_i),    32'h7);
        end

        // Three back-to-back commands.
        set_cmd(1, 4'b0011, 2'b11, 3'd1);
        tick();
        set_cmd(1, 4'b1000, 2'b10, 3'd0);
        tick();
        ops[0] = dut_op; dns[0] = dut_done;
        set_cmd(1, 4'b1111, 2'b01, 3'd2);
        tick();
        ops[1] = dut_op; dns[1] = dut_done;
        set_cmd(0, '0, '0, '0);
        for (int k = 2; k < 6; k++) begin
            tick();
            ops[k] = dut_op;
            dns[k] = dut_done;
        end
        for (int k = 0; k < 6; k++) begin
            check("t3_op",   32'(ops[k]), 32'(exp_ops[k]));
            check("t3_done", 32'(dns[k]), 32'(exp_done[k]));
        end
        wait_idle("t3_drain", 50);

        // Fill the FIFO behind a long command.
        acc_cnt = 0;
        set_cmd(1, 4'b0101, 2'b11, 3'd7);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!cmd_if.cmd_ready) break;
        end
        set_cmd(0, '0, '0, '0);
        check("t4_ready_lo", 32'(cmd_if.cmd_ready), 32'd0);
        check("t4_accepts",  32'(acc_cnt),          32'd5);
        wait_idle("t4_drain", 100);

        // Asynchronous reset mid-issue with two entries queued.
        set_cmd(1, 4'b1100, 2'b10, 3'd7);
        tick();
        set_cmd(1, 4'b0110, 2'b01, 3'd2);
        tick();
        set_cmd(1, 4'b1001, 2'b11, 3'd1);
        tick();
        set_cmd(0, '0, '0, '0);
        tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_i",    32'(dut_i),    32'd0);
        check("t5_op",   32'(dut_op),   32'd0);
        check("t5_busy", 32'(dut_busy), 32'd0);
        check("t5_done", 32'(dut_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_quiet_op",   32'(dut_op),   32'd0);
            check("t5_quiet_busy", 32'(dut_busy), 32'd0);
        end

`ifdef SHIFTREG_SEQ_FLUSH_EN
        // Flush during issue with a concurrent push.
        set_cmd(1, 4'b1010, 2'b10, 3'd5);
        tick();
        set_cmd(1, 4'b0001, 2'b10, 3'd2);
        tick();
        tick();
        set_cmd(1, 4'b1110, 2'b11, 3'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_cmd(0, '0, '0, '0);
        check("t6_op",    32'(dut_op),            32'd0);
        check("t6_busy",  32'(dut_busy),          32'd0);
        check("t6_ready", 32'(cmd_if.cmd_ready),  32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_no_issue", 32'(dut_op), 32'd0);
        end
`endif

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            set_cmd($urandom_range(0, 99) < 45, 4'($urandom), 2'($urandom),
                    ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1)));
`ifdef SHIFTREG_SEQ_FLUSH_EN
            flush = ($urandom_range(0, 99) == 0);
`endif
            tick();
        end
        set_cmd(0, '0, '0, '0);
        flush = 1'b0;
        wait_idle("rand_drain", 200);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/shiftreg_cmd_seq.md
Name: shiftreg_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit shift register and drives its data input i and op-code input op.
- Accepts commands over a valid/ready interface and buffers them in a small FIFO.
- Each command holds its data/op pair on the shift-register inputs for a programmable number of consecutive clocks.
- Lets the shift register's software-style drivers queue multi-step shift sequences without cycle-accurate timing.

Parameters:
DW, 4, data width; equals shift register width.
OW, 2, op-code width.
CW, 3, repeat-count field width.
DEPTH, 4, FIFO entries; power of 2, minimum 2.
IDLE_OP, 2'b00, op value driven when no command is issuing.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_data  input  DW  data to present on i
cmd_op  input  OW  op-code to present on op
cmd_cnt  input  CW  repeat count; command is issued for cmd_cnt+1 cycles
i  output  DW  data to shift register, registered
op  output  OW  op-code to shift register, registered
busy  output  1  high while a command is issuing or the FIFO is non-empty
done  output  1  high during the final issue cycle of each command

Behaviour:
- Reset values (rst asserted, asynchronous, any time):
  - FIFO is emptied; read/write pointers and occupancy go to 0.
  - FSM goes to IDLE; repeat counter goes to 0.
  - Outputs: i=0, op=IDLE_OP, busy=0, done=0.
  - A command mid-issue is discarded with no further issue cycles.
- Push:
  - Occurs at a rising edge when cmd_valid && cmd_ready.
  - cmd_ready = (occupancy != DEPTH), decoded from registered state only.
  - A pop in the same cycle does not raise cmd_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
- FSM states: IDLE, ISSUE.
  - IDLE: if FIFO non-empty, pop head at the edge, load i/op/counter := head.cnt, go to ISSUE. Otherwise i holds its last value and op=IDLE_OP.
  - ISSUE with counter != 0: decrement counter; i/op held.
  - ISSUE with counter == 0 (final cycle, done=1):
    - FIFO non-empty: pop the next command at this edge and stay in ISSUE. Back-to-back commands have no idle gap.
    - FIFO empty: go to IDLE; op:=IDLE_OP.
- Latency: command pushed at edge N into an empty FIFO while IDLE → i/op valid after edge N+1.
- Cycle accounting: a command with cnt=k occupies exactly k+1 cycles on op.
- done: registered; asserted exactly in the cycle whose counter value is 0.
- busy: registered; = (state==ISSUE) || (occupancy != 0), evaluated from next-state values.
- Pointers wrap modulo DEPTH.
- Occupancy counter is CW-independent, width log2(DEPTH)+1.
- No arithmetic on data; cmd_data/cmd_op are passed through unchanged.

Optional Feature:
Macro SHIFTREG_SEQ_FLUSH_EN.
- Defined: adds input port flush (1 bit, placed after rst).
  - flush=1 at an edge empties the FIFO and aborts any issuing command.
  - Next state IDLE; op=IDLE_OP, done=0, busy=0.
  - A push in the same cycle is dropped.
  - cmd_ready is 1 in the following cycle.
- Undefined: no flush port; FIFO and FSM are cleared only by rst.

Test Plan:
- Reset, then push {data=1011, op=01, cnt=0} → after edge N+1, i=1011, op=01, done=1 for exactly 1 cycle; then op=00, busy=0.
- Push {0111, 10, cnt=3} → op=10 for exactly 4 consecutive cycles; done only on the 4th; i=0111 throughout.
- Push 3 commands back-to-back {0011,11,1}, {1000,10,0}, {1111,01,2} → op sequence 11,11,10,01,01,01 with no IDLE_OP gap; done pulses at cycles 2, 3, 6.
- Hold cmd_valid=1 with cnt=7 until cmd_ready falls → exactly DEPTH=4 commands accepted while the first is issuing; cmd_ready=0 while full; rises the cycle after the next pop.
- Assert rst asynchronously mid-ISSUE with FIFO holding 2 entries → i=0, op=00, busy=0, done=0 immediately; nothing issues after rst is released until a new push.
- (SHIFTREG_SEQ_FLUSH_EN) flush during ISSUE with a concurrent push → next cycle op=00, busy=0, cmd_ready=1; the pushed command never appears on op.
